// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcode field width, opcode encodings and the
// helper that extracts the opcode from a 32-bit instruction word.
package mips_pkg;

  localparam int OPC_W   = 6;
  localparam int INSTR_W = 32;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD   = 6'b000000,
    OPC_SUB   = 6'b000001,
    OPC_AND   = 6'b000010,
    OPC_OR    = 6'b000011,
    OPC_SLT   = 6'b000100,
    OPC_MUL   = 6'b000101,
    OPC_LW    = 6'b001000,
    OPC_SW    = 6'b001001,
    OPC_ADDI  = 6'b001010,
    OPC_SUBI  = 6'b001011,
    OPC_SLTI  = 6'b001100,
    OPC_JUMP  = 6'b001101,
    OPC_BEQZ  = 6'b001110,
    OPC_BNEQZ = 6'b001111,
    OPC_HALT  = 6'b111111
  } opcode_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/mips_imem.sv
// Instruction memory: one write port, one read port, DATA_W x DEPTH.
// The read address is presented combinationally; the synchronous read
// register is the IF/ID instruction register in mips_fetch_unit, so a
// fetch and a write to the same word in one cycle return the old word.
module mips_imem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk1,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port; contents survive reset.
  always_ff @(posedge clk1) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS32 instruction-fetch stage: PC, instruction memory, IF/ID register
// with valid/ready handshake toward decode, EX redirect with wrong-path
// flush, and fetch stop on HALT.
// Optional build macro: FETCH_JUMP_EARLY_EN - redirect the PC on a fetched
// JUMP without waiting for EX.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int IMEM_DEPTH = 64,
  parameter  int RESET_PC   = 0,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic              ex_redirect,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_npc,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_instr;
  logic [PC_W-1:0]   r_if_pc;
  logic [PC_W-1:0]   r_if_npc;
  logic [PC_W-1:0]   r_pc;
  logic              r_halted;

  logic [DATA_W-1:0] w_rd_word;
  logic [OPC_W-1:0]  w_opcode;
  logic              w_fire;
  logic [PC_W-1:0]   w_pc_seq;
  logic [PC_W-1:0]   w_pc_fetch_next;

  mips_imem #(
    .DATA_W (DATA_W),
    .DEPTH  (IMEM_DEPTH)
  ) u_imem (
    .clk1    (clk1),
    .i_we    (imem_we),
    .i_waddr (imem_waddr),
    .i_wdata (imem_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_rd_word)
  );

  // Fetch handshake and next fetch address; the PC width makes +1 wrap modulo IMEM_DEPTH.
  always_comb begin
    w_opcode        = w_rd_word[DATA_W-1 -: OPC_W];
    w_fire          = !r_halted && (!r_if_valid || id_ready);
    w_pc_seq        = r_pc + 1'b1;
    w_pc_fetch_next = w_pc_seq;
`ifdef FETCH_JUMP_EARLY_EN
    if (w_opcode == OPC_JUMP) begin
      w_pc_fetch_next = w_rd_word[PC_W-1:0];
    end
`else
`endif
  end

  // PC, IF/ID register and halt flag; reset beats redirect, redirect beats fetch and stall.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_if_npc   <= '0;
      r_halted   <= 1'b0;
    end else if (ex_redirect) begin
      r_pc       <= ex_target;
      r_if_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else if (w_fire) begin
      r_if_instr <= w_rd_word;
      r_if_pc    <= r_pc;
      r_if_npc   <= w_pc_seq;
      r_if_valid <= 1'b1;
      r_pc       <= w_pc_fetch_next;
      if (w_opcode == OPC_HALT) begin
        r_halted <= 1'b1;
      end
    end else if (id_ready) begin
      // Halted and decode has taken the last instruction.
      r_if_valid <= 1'b0;
    end
  end

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;
  assign if_npc   = r_if_npc;
  assign pc       = r_pc;
  assign halted   = r_halted;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit (IMEM_DEPTH=16): sequential fetch,
// stall, HALT, redirect, early jump (when FETCH_JUMP_EARLY_EN is defined),
// PC wrap, read-before-write and reset during stall/redirect.
module tb_mips_fetch_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [DW-1:0] HALT_W  = 32'hFC00_0000;
  localparam logic [DW-1:0] JUMP3_W = 32'h3400_0003;
  localparam logic [DW-1:0] NEW_W   = 32'h0ABC_0002;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic          ex_redirect;
  logic [AW-1:0] ex_target;
  logic          id_ready;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_npc;
  logic [AW-1:0] pc;
  logic          halted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk1 = ~clk1;

  mips_fetch_unit #(
    .DATA_W     (DW),
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (0)
  ) dut (
    .clk1        (clk1),
    .rst         (rst),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_npc      (if_npc),
    .pc          (pc),
    .halted      (halted)
  );

  function automatic logic [DW-1:0] ins(input int n);
    return 32'h0010_0000 + 32'(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic redirect(input int tgt);
    ex_redirect = 1'b1;
    ex_target   = AW'(tgt);
    step();
    ex_redirect = 1'b0;
  endtask

  int            load_addr [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};
  logic [DW-1:0] load_data [12];
  int            exp_after_jump;

  initial begin
    load_data = '{ins(0), ins(1), ins(2), ins(3), ins(4), HALT_W, ins(6), ins(7),
                  JUMP3_W, ins(9), ins(10), ins(15)};
`ifdef FETCH_JUMP_EARLY_EN
    exp_after_jump = 3;
`else
    exp_after_jump = 9;
`endif

    rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    ex_redirect = 1'b0; ex_target = '0; id_ready = 1'b1;
    step();
    // Load IMEM while held in reset.
    for (int i = 0; i < 12; i++) begin
      imem_we = 1'b1; imem_waddr = AW'(load_addr[i]); imem_wdata = load_data[i];
      step();
    end
    imem_we = 1'b0;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_npc", 32'(if_npc), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Sequential fetch I0..I3.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("seq_instr", if_instr, ins(i));
      check("seq_if_pc", 32'(if_pc), 32'(i));
      check("seq_valid", 32'(if_valid), 32'd1);
    end
    check("seq_pc_end", 32'(pc), 32'd4);
    check("seq_npc_end", 32'(if_npc), 32'd4);

    // Redirect flushes, then stall with I1 in IF/ID.
    redirect(1);
    check("rdr_valid", 32'(if_valid), 32'd0);
    check("rdr_pc", 32'(pc), 32'd1);
    id_ready = 1'b0;
    step();
    check("stl_first", if_instr, ins(1));
    check("stl_first_pc", 32'(pc), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_instr", if_instr, ins(1));
      check("stl_if_pc", 32'(if_pc), 32'd1);
      check("stl_pc", 32'(pc), 32'd2);
      check("stl_valid", 32'(if_valid), 32'd1);
    end
    id_ready = 1'b1;
    step();
    check("stl_release", if_instr, ins(2));
    check("stl_rel_pc", 32'(pc), 32'd3);

    // HALT at address 5.
    step();
    step();
    check("pre_halt", if_instr, ins(4));
    step();
    check("halt_instr", if_instr, HALT_W);
    check("halt_if_pc", 32'(if_pc), 32'd5);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd6);
    check("halt_valid", 32'(if_valid), 32'd1);
    id_ready = 1'b0;
    step();
    check("halt_hold_valid", 32'(if_valid), 32'd1);
    check("halt_hold_pc", 32'(pc), 32'd6);
    id_ready = 1'b1;
    step();
    check("drain_valid", 32'(if_valid), 32'd0);
    check("drain_halted", 32'(halted), 32'd1);
    check("drain_pc", 32'(pc), 32'd6);
    step();
    check("drain2_valid", 32'(if_valid), 32'd0);
    check("drain2_pc", 32'(pc), 32'd6);
    check("drain2_if_pc", 32'(if_pc), 32'd5);

    // Redirect out of halt.
    redirect(9);
    check("unhalt_flag", 32'(halted), 32'd0);
    check("unhalt_valid", 32'(if_valid), 32'd0);
    check("unhalt_pc", 32'(pc), 32'd9);
    step();
    check("tgt_instr", if_instr, ins(9));
    check("tgt_if_pc", 32'(if_pc), 32'd9);
    check("tgt_npc", 32'(if_npc), 32'd10);
    check("tgt_valid", 32'(if_valid), 32'd1);

    // JUMP at address 8 targeting 3.
    redirect(8);
    step();
    check("jmp_instr", if_instr, JUMP3_W);
    check("jmp_npc", 32'(if_npc), 32'd9);
    check("jmp_pc", 32'(pc), 32'(exp_after_jump));
    step();
    check("jmp_next_if_pc", 32'(if_pc), 32'(exp_after_jump));
    check("jmp_next_instr", if_instr, ins(exp_after_jump));
    check("jmp_next_valid", 32'(if_valid), 32'd1);

    // PC wrap: 15 -> 0 -> 1.
    redirect(15);
    step();
    check("wrap_instr15", if_instr, ins(15));
    check("wrap_npc15", 32'(if_npc), 32'd0);
    check("wrap_pc", 32'(pc), 32'd0);
    step();
    check("wrap_if_pc0", 32'(if_pc), 32'd0);
    check("wrap_instr0", if_instr, ins(0));
    step();
    check("wrap_if_pc1", 32'(if_pc), 32'd1);

    // Fetch and write of address 2 in the same cycle returns the old word.
    imem_we = 1'b1; imem_waddr = 4'd2; imem_wdata = NEW_W;
    step();
    imem_we = 1'b0;
    check("rbw_old", if_instr, ins(2));
    check("rbw_if_pc", 32'(if_pc), 32'd2);
    redirect(2);
    step();
    check("rbw_new", if_instr, NEW_W);

    // Reset during a stall with a redirect pending.
    id_ready = 1'b0;
    step();
    ex_redirect = 1'b1; ex_target = 4'd7; rst = 1'b1;
    step();
    ex_redirect = 1'b0;
    check("rst2_valid", 32'(if_valid), 32'd0);
    check("rst2_instr", if_instr, 32'd0);
    check("rst2_pc", 32'(pc), 32'd0);
    check("rst2_if_pc", 32'(if_pc), 32'd0);
    check("rst2_npc", 32'(if_npc), 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
